expr_eval: RTL

Downstream stage of the ASCII digit/operator string recognizer. Consumes the same 8-bit character stream, one character per qualified clock. Evaluates single-digit integer expressions with `+`, `-` and `*`, using standard precedence (`*` binds tighter). On the terminating `=` it emits the modulo-2^W result or an error flag.

---
 rtl/expr_eval_pkg.sv | 32 +++
 rtl/expr_eval_if.sv | 27 ++
 rtl/expr_eval_char_class.sv | 33 +++
 rtl/expr_eval.sv | 134 +++++++++++++
 4 files changed

// File: rtl/expr_eval_pkg.sv
// Shared character constants, state encoding and character-class types for the
// ASCII expression pipeline (recognizer and evaluator).
package expr_eval_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_EQ    = 8'h3D;

    typedef enum logic [1:0] {
        S_NUM = 2'd0,
        S_OP  = 2'd1,
        ERR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_OP    = 2'd1,
        CLS_EQ    = 2'd2,
        CLS_OTHER = 2'd3
    } cls_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_NONE = 2'd3
    } op_t;

endpackage

// File: rtl/expr_eval_if.sv
// Character stream in, evaluated result out. The master side drives characters;
// the slave side (the evaluator) returns result/done/err.
interface expr_eval_if #(
    parameter int W = 16
);
    logic [7:0]   in;
    logic         in_valid;
    logic [W-1:0] result;
    logic         done;
    logic         err;

    modport master (
        output in,
        output in_valid,
        input  result,
        input  done,
        input  err
    );

    modport slave (
        input  in,
        input  in_valid,
        output result,
        output done,
        output err
    );
endinterface

// File: rtl/expr_eval_char_class.sv
// Combinational decode of one ASCII character into class, digit value and
// operator kind; shared with the upstream recognizer.
module char_class
    import expr_eval_pkg::*;
(
    input  logic [7:0] ch_i,
    output cls_t       cls_o,
    output logic [3:0] digit_o,
    output op_t        op_o
);

    always_comb begin
        cls_o   = CLS_OTHER;
        op_o    = OP_NONE;
        // '0' is 8'h30, so the low nibble already equals the digit value
        digit_o = ch_i[3:0];
        if (ch_i >= CH_0 && ch_i <= CH_9) begin
            cls_o = CLS_DIGIT;
        end else if (ch_i == CH_PLUS) begin
            cls_o = CLS_OP;
            op_o  = OP_ADD;
        end else if (ch_i == CH_MINUS) begin
            cls_o = CLS_OP;
            op_o  = OP_SUB;
        end else if (ch_i == CH_MUL) begin
            cls_o = CLS_OP;
            op_o  = OP_MUL;
        end else if (ch_i == CH_EQ) begin
            cls_o = CLS_EQ;
        end
    end

endmodule

// File: rtl/expr_eval.sv
// Single-digit +,-,* expression evaluator with '*' precedence; result is emitted
// one cycle after '=' together with an error qualifier.
//
//   state | meaning
//   S_NUM | expecting a digit
//   S_OP  | expecting an operator or '='
//   ERR   | malformed input seen, swallowing until '='
module expr_eval
    import expr_eval_pkg::*;
#(
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          clr,
    expr_eval_if.slave    bus
);

    cls_t       cls;
    logic [3:0] digit;
    op_t        op;

    char_class u_char_class (
        .ch_i    (bus.in),
        .cls_o   (cls),
        .digit_o (digit),
        .op_o    (op)
    );

    state_t       state_q;
    logic [W-1:0] sum_q;
    logic [W-1:0] term_q;
    logic         neg_q;
    logic         mulp_q;
    logic [W-1:0] result_q;
    logic         done_q;
    logic         err_q;

    logic [W-1:0] digit_ext_d;
    logic [W-1:0] signed_term_d;
    logic [W-1:0] commit_d;
    logic [W-1:0] prod_d;

    assign digit_ext_d   = {{(W-4){1'b0}}, digit};
    assign signed_term_d = neg_q ? (-term_q) : term_q;
    assign commit_d      = sum_q + signed_term_d;
    assign prod_d        = term_q * digit_ext_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_NUM;
            sum_q    <= '0;
            term_q   <= '0;
            neg_q    <= 1'b0;
            mulp_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.in_valid) begin
                case (state_q)
                    S_NUM: begin
                        case (cls)
                            CLS_DIGIT: begin
                                term_q  <= mulp_q ? prod_d : digit_ext_d;
                                state_q <= S_OP;
                            end
                            CLS_EQ: begin
                                result_q <= '0;
                                done_q   <= 1'b1;
                                err_q    <= 1'b1;
                                sum_q    <= '0;
                                term_q   <= '0;
                                neg_q    <= 1'b0;
                                mulp_q   <= 1'b0;
                            end
                            default: state_q <= ERR;
                        endcase
                    end
                    S_OP: begin
                        case (cls)
                            CLS_OP: begin
                                state_q <= S_NUM;
                                case (op)
                                    OP_ADD: begin
                                        sum_q  <= commit_d;
                                        neg_q  <= 1'b0;
                                        mulp_q <= 1'b0;
                                    end
                                    OP_SUB: begin
                                        sum_q  <= commit_d;
                                        neg_q  <= 1'b1;
                                        mulp_q <= 1'b0;
                                    end
                                    default: mulp_q <= 1'b1;
                                endcase
                            end
                            CLS_EQ: begin
                                result_q <= commit_d;
                                done_q   <= 1'b1;
                                err_q    <= 1'b0;
                                sum_q    <= '0;
                                term_q   <= '0;
                                neg_q    <= 1'b0;
                                mulp_q   <= 1'b0;
                                state_q  <= S_NUM;
                            end
                            // a second digit means a multi-digit number, which is illegal
                            default: state_q <= ERR;
                        endcase
                    end
                    ERR: begin
                        if (cls == CLS_EQ) begin
                            result_q <= '0;
                            done_q   <= 1'b1;
                            err_q    <= 1'b1;
                            sum_q    <= '0;
                            term_q   <= '0;
                            neg_q    <= 1'b0;
                            mulp_q   <= 1'b0;
                            state_q  <= S_NUM;
                        end
                    end
                    default: state_q <= S_NUM;
                endcase
            end
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule
